// File: rtl/inst_fetch_buf.sv
// Instruction prefetch FIFO with registered IF/ID output stage.
// Optional INST_FETCH_BUF_BYPASS_EN: empty-queue push goes straight to id_* (1-edge latency).
module inst_fetch_buf #(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush_i,
   input  logic             id_stall_i,
   input  logic             fetch_valid_i,
   input  logic [31:0]      fetch_pc_i,
   input  logic [31:0]      fetch_inst_i,
   output logic             fetch_ready_o,
   output logic [31:0]      id_pc_o,
   output logic [31:0]      id_inst_o,
   output logic             id_valid_o,
   output logic [PTR_W:0]   count_o
);

   logic [63:0]    mem_q [DEPTH];
   logic [63:0]    mem_d [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic [31:0]    id_pc_q, id_pc_d;
   logic [31:0]    id_inst_q, id_inst_d;
   logic           id_valid_q, id_valid_d;

   logic full, push, take, pop, byp, wr;

   always_comb begin
      full          = (count_q == (PTR_W+1)'(DEPTH));
      fetch_ready_o = rst && !flush_i && !full;
      push          = fetch_valid_i && fetch_ready_o;
      take          = !flush_i && !id_stall_i;
      pop           = take && (count_q != '0);
`ifdef INST_FETCH_BUF_BYPASS_EN
      byp           = take && (count_q == '0) && push;
`else
      byp           = 1'b0;
`endif
      wr            = push && !byp;
   end

   always_comb begin
      mem_d      = mem_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      id_pc_d    = id_pc_q;
      id_inst_d  = id_inst_q;
      id_valid_d = id_valid_q;
      if (flush_i) begin
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
         id_pc_d    = '0;
         id_inst_d  = '0;
         id_valid_d = 1'b0;
      end else begin
         if (wr) begin
            mem_d[wr_ptr_q] = {fetch_pc_i, fetch_inst_i};
            wr_ptr_d        = wr_ptr_q + 1'b1;
         end
         if (pop) begin
            {id_pc_d, id_inst_d} = mem_q[rd_ptr_q];
            id_valid_d           = 1'b1;
            rd_ptr_d             = rd_ptr_q + 1'b1;
         end else if (byp) begin
            id_pc_d    = fetch_pc_i;
            id_inst_d  = fetch_inst_i;
            id_valid_d = 1'b1;
         end else if (take) begin
            id_pc_d    = '0;
            id_inst_d  = '0;
            id_valid_d = 1'b0;
         end
         count_d = count_q + (PTR_W+1)'(wr) - (PTR_W+1)'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         id_pc_q    <= '0;
         id_inst_q  <= '0;
         id_valid_q <= 1'b0;
      end else begin
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         id_pc_q    <= id_pc_d;
         id_inst_q  <= id_inst_d;
         id_valid_q <= id_valid_d;
      end
   end

   // Storage contents are don't-care after reset, so no reset term here.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign id_pc_o    = id_pc_q;
   assign id_inst_o  = id_inst_q;
   assign id_valid_o = id_valid_q;
   assign count_o    = count_q;

endmodule

// File: tb/tb_inst_fetch_buf.sv
// Directed bench for inst_fetch_buf with a queue model of the FIFO contents.
module tb_inst_fetch_buf;

   logic        clk;
   logic        rst;
   logic        flush_i;
   logic        id_stall_i;
   logic        fetch_valid_i;
   logic [31:0] fetch_pc_i;
   logic [31:0] fetch_inst_i;
   logic        fetch_ready_o;
   logic [31:0] id_pc_o;
   logic [31:0] id_inst_o;
   logic        id_valid_o;
   logic [2:0]  count_o;

   inst_fetch_buf #(.DEPTH(4), .PTR_W(2)) dut (
      .clk           (clk),
      .rst           (rst),
      .flush_i       (flush_i),
      .id_stall_i    (id_stall_i),
      .fetch_valid_i (fetch_valid_i),
      .fetch_pc_i    (fetch_pc_i),
      .fetch_inst_i  (fetch_inst_i),
      .fetch_ready_o (fetch_ready_o),
      .id_pc_o       (id_pc_o),
      .id_inst_o     (id_inst_o),
      .id_valid_o    (id_valid_o),
      .count_o       (count_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   logic [63:0] sb_q[$];
   logic [31:0] exp_pc;
   logic [31:0] exp_inst;
   logic        exp_valid;
   logic        pushed;

   function automatic logic [31:0] inst_of(input logic [31:0] pc);
      return ~pc ^ 32'h0013_0000;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, check ready, advance model, check registered outputs.
   task automatic step(input logic rstn, input logic flush, input logic stall,
                       input logic v, input logic [31:0] pc, output logic did_push);
      logic exp_ready;
      logic take;
      logic bypassed;
      @(negedge clk);
      rst           = rstn;
      flush_i       = flush;
      id_stall_i    = stall;
      fetch_valid_i = v;
      fetch_pc_i    = pc;
      fetch_inst_i  = inst_of(pc);
      #1;
      exp_ready = rstn && !flush && (sb_q.size() != 4);
      chk("fetch_ready", 64'(fetch_ready_o), 64'(exp_ready));
      did_push = v && exp_ready;
      bypassed = 1'b0;
      if (!rstn || flush) begin
         sb_q.delete();
         exp_pc = '0; exp_inst = '0; exp_valid = 1'b0;
      end else begin
         take = !stall;
`ifdef INST_FETCH_BUF_BYPASS_EN
         if (take && sb_q.size() == 0 && did_push) begin
            exp_pc = pc; exp_inst = inst_of(pc); exp_valid = 1'b1;
            bypassed = 1'b1;
         end
`endif
         if (!bypassed) begin
            if (take && sb_q.size() != 0) begin
               {exp_pc, exp_inst} = sb_q.pop_front();
               exp_valid = 1'b1;
            end else if (take) begin
               exp_pc = '0; exp_inst = '0; exp_valid = 1'b0;
            end
            if (did_push) sb_q.push_back({pc, inst_of(pc)});
         end
      end
      @(posedge clk);
      #1;
      chk("id_valid", 64'(id_valid_o), 64'(exp_valid));
      chk("id_pc",    64'(id_pc_o),    64'(exp_pc));
      chk("id_inst",  64'(id_inst_o),  64'(exp_inst));
      chk("count",    64'(count_o),    64'(sb_q.size()));
   endtask

   initial begin
      rst = 1'b0; flush_i = 1'b0; id_stall_i = 1'b0;
      fetch_valid_i = 1'b0; fetch_pc_i = '0; fetch_inst_i = '0;
      exp_pc = '0; exp_inst = '0; exp_valid = 1'b0;

      // Reset held for two edges
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, pushed);
      step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, pushed);

      // Stream of three back-to-back pairs
      for (int unsigned k = 0; k < 3; k++)
         step(1'b1, 1'b0, 1'b0, 1'b1, 32'(k * 4), pushed);
      for (int unsigned k = 0; k < 3; k++)
         step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, pushed);

      // Fill to full under stall, fifth pair held off
      for (int unsigned k = 0; k < 4; k++)
         step(1'b1, 1'b0, 1'b1, 1'b1, 32'h10 + 32'(k * 4), pushed);
      step(1'b1, 1'b0, 1'b1, 1'b1, 32'h20, pushed);
      chk("full_holds_off", 64'(pushed), 64'(0));
      for (int unsigned c = 0; c < 4 && !pushed; c++)
         step(1'b1, 1'b0, 1'b0, 1'b1, 32'h20, pushed);
      for (int unsigned k = 0; k < 6; k++)
         step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, pushed);

      // Wrap-around with stall toggling every 3 cycles
      begin
         int unsigned k;
         k = 0;
         for (int unsigned c = 0; c < 100 && k < 10; c++) begin
            step(1'b1, 1'b0, ((c / 3) % 2) == 1, 1'b1, 32'h100 + 32'(k * 4), pushed);
            if (pushed) k++;
         end
         chk("wrap_all_pushed", 64'(k), 64'(10));
      end
      for (int unsigned k = 0; k < 6; k++)
         step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, pushed);

      // Flush with full queue and stall; 0x40 must be dropped
      for (int unsigned k = 0; k < 4; k++)
         step(1'b1, 1'b0, 1'b1, 1'b1, 32'h200 + 32'(k * 4), pushed);
      step(1'b1, 1'b1, 1'b1, 1'b1, 32'h40, pushed);
      step(1'b1, 1'b0, 1'b0, 1'b1, 32'h80, pushed);
      for (int unsigned k = 0; k < 3; k++)
         step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, pushed);

      // Simultaneous push and pop at count 2
      step(1'b1, 1'b0, 1'b1, 1'b1, 32'h50, pushed);
      step(1'b1, 1'b0, 1'b1, 1'b1, 32'h54, pushed);
      step(1'b1, 1'b0, 1'b0, 1'b1, 32'h30, pushed);
      chk("pushpop_count", 64'(count_o), 64'(2));
      for (int unsigned k = 0; k < 4; k++)
         step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, pushed);

      // Reset mid-stream at count 3
      for (int unsigned k = 0; k < 3; k++)
         step(1'b1, 1'b0, 1'b1, 1'b1, 32'h60 + 32'(k * 4), pushed);
      step(1'b0, 1'b0, 1'b0, 1'b1, 32'h6C, pushed);
      chk("rst_ready_low", 64'(fetch_ready_o), 64'(0));
      step(1'b1, 1'b0, 1'b0, 1'b1, 32'h70, pushed);
      for (int unsigned k = 0; k < 3; k++)
         step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, pushed);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
